// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
// Holds the FSM encoding and the default operand width.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// 1-bit full subtractor, purely combinational (zero latency).
// No handshake: the controller steers one bit pair per cycle through it.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b through one shared full_sub_cell, LSB first; done pulses WIDTH+1 cycles after start.
// start is ignored outside IDLE; optional zero/lt flags under SERIAL_SUB_FLAGS_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             lt
`endif
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             run;
  logic             last;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] s_shift;

  full_sub_cell u_cell (
    .a    (ar[0]),
    .b    (br[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last    = (cnt == LAST_BIT);
  assign s_shift = {cell_d, s[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The unused encoding falls into the default arm and behaves as IDLE.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    run       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        busy = 1'b1;
        run  = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar     <= '0;
      br     <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      s      <= '0;
      borrow <= 1'b0;
    end else if (load) begin
      ar     <= a;
      br     <= b;
      cnt    <= '0;
      brw    <= 1'b0;
      s      <= '0;
      borrow <= 1'b0;
    end else if (run) begin
      ar  <= ar >> 1;
      br  <= br >> 1;
      cnt <= cnt + CNT_W'(1);
      brw <= cell_bout;
      s   <= s_shift;
      if (last) begin
        borrow <= cell_bout;
      end
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  // Flags are captured alongside the final bit so they hold exactly as long as s.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      zero <= 1'b0;
      lt   <= 1'b0;
    end else if (run && last) begin
      zero <= (s_shift == '0);
      lt   <= cell_bout;
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl with a cycle-count reference model and per-cycle compare.
module tb_serial_sub_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         borrow;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero;
  logic         lt;
`endif

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .s      (s),
    .borrow (borrow)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero   (zero),
    .lt     (lt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  bit started  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a request occupies W cycles of work, then a one-cycle done.
  int           rem   = 0;
  bit           mdone = 0;
  logic [W-1:0] ms    = '0;
  bit           mb    = 0;
  logic [W-1:0] pend_s;
  bit           pend_b;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      rem = 0; mdone = 0; ms = '0; mb = 0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        mdone = 1; ms = pend_s; mb = pend_b;
      end
    end else if (mdone) begin
      mdone = 0;
    end else if (start) begin
      rem    = W;
      pend_s = W'(a - b);
      pend_b = (a < b);
      ms     = '0;
      mb     = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("busy", 32'(busy), 32'(rem > 0));
      check("done", 32'(done), 32'(mdone));
      if (done) done_cnt++;
      if (rem == 0) begin
        check("s_model", 32'(s), 32'(ms));
        check("borrow_model", 32'(borrow), 32'(mb));
`ifdef SERIAL_SUB_FLAGS_EN
        check("zero_model", 32'(zero), 32'(mdone || !mb ? (ms == 0 && (mdone || ms != pend_s || 1'b1)) : 1'b0));
        check("lt_model", 32'(lt), 32'(mb));
`endif
      end
    end
  end

  // Issue one request on an IDLE cycle, wait bounded for done, check latency and result.
  task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb,
                    input logic [W-1:0] es, input bit eb);
    int n = 0;
    int nb = 0;
    a = va; b = vb; start = 1'b1;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) nb++;
    end while (!done && n < 20);
    check("latency", 32'(n), 32'd5);
    check("busy_cycles", 32'(nb), 32'd4);
    check("s", 32'(s), 32'(es));
    check("borrow", 32'(borrow), 32'(eb));
    @(negedge clk);
  endtask

  initial begin
    int pre;
    int reqs;
    int n;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    @(posedge clk);
    started = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    @(negedge clk);

    op(4'd5,  4'd3,  4'b0010, 1'b0);
    op(4'd3,  4'd5,  4'b1110, 1'b1);
    op(4'd0,  4'd1,  4'b1111, 1'b1);
    op(4'd15, 4'd15, 4'b0000, 1'b0);

    // start while running and start during DONE must both be ignored
    a = 4'd9; b = 4'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk); n++;
    end
    check("ign_s", 32'(s), 32'd5);
    check("ign_borrow", 32'(borrow), 32'd0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("ign_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("ign_hold_s", 32'(s), 32'd5);

    // reset on the second RUN cycle discards the operation
    a = 4'd12; b = 4'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    pre = done_cnt;
    @(negedge clk); reset = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_s", 32'(s), 32'd0);
    check("mid_borrow", 32'(borrow), 32'd0);
    repeat (8) @(negedge clk);
    check("mid_no_done", 32'(done_cnt), 32'(pre));
    op(4'd12, 4'd7, 4'b0101, 1'b0);

    pre  = done_cnt;
    reqs = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op(W'(i), W'(j), W'(i - j), (i < j));
        reqs++;
      end
    end
    check("sweep_done_pulses", 32'(done_cnt - pre), 32'(reqs));

`ifdef SERIAL_SUB_FLAGS_EN
    op(4'd6, 4'd6, 4'd0, 1'b0);
    check("flag_zero_eq", 32'(zero), 32'd1);
    check("flag_lt_eq", 32'(lt), 32'd0);
    op(4'd2, 4'd7, 4'd11, 1'b1);
    check("flag_zero_lt", 32'(zero), 32'd0);
    check("flag_lt_lt", 32'(lt), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction sequencer that computes a - b by routing one bit pair per clock through a single shared 1-bit full-subtractor cell.
- Holds the running borrow between cycles.
- Replaces a WIDTH-wide ripple-borrow chain when area matters more than latency.
- Sits between a requesting unit (start/done handshake) and the shared subtractor cell.

Parameters:
- WIDTH, 4, operand and result width in bits (minimum 2).
- CNT_W, $clog2(WIDTH)+1, width of the internal bit counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; a and b are sampled when start is accepted.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse when the result becomes valid.
- s  output  WIDTH  difference (a - b) mod 2^WIDTH.
- borrow  output  1  final borrow out; 1 iff a < b, unsigned.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0 (busy, done, s, borrow); FSM = IDLE; counter = 0; internal borrow = 0; operand shift registers = 0.
- FSM states and transitions:
  - IDLE -> RUN when start=1. On that edge: latch a and b into shift registers, clear counter and internal borrow, set busy=1.
  - RUN, one bit per cycle, LSB first:
    - Cell inputs are ar[0], br[0] and the internal borrow.
    - Each edge: shift the difference bit into s from the MSB side, update the borrow from the cell, shift ar and br right, increment the counter.
    - RUN -> DONE on the edge that processes bit WIDTH-1.
  - DONE: done=1, busy=0, s and borrow valid. Next edge: DONE -> IDLE, done=0.
- Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from start to done.
- Output hold: s and borrow hold their last value after DONE until the next start is accepted. On acceptance they are cleared to 0.
- Start handling:
  - start while busy=1 (RUN) is ignored; latched operands do not change.
  - start during DONE is also ignored. The requester re-asserts start in IDLE.
  - Back-to-back: minimum request spacing is WIDTH+2 cycles.
- Reset mid-operation: at the next edge go to IDLE and clear every output and internal register; the partial result is discarded with no done pulse.
- Reset and start in the same cycle: reset wins.
- Boundaries:
  - a = b -> s = 0, borrow = 0.
  - 0 - 1 wraps to all ones with borrow = 1.
  - Operands are unsigned only.

Optional Feature:
- Macro SERIAL_SUB_FLAGS_EN.
- When defined, two extra outputs are added:
  - zero (1 bit): s == 0.
  - lt (1 bit): equals the final borrow.
- Both flags are registered, valid with done, held with s, and reset to 0.
- When undefined, the ports do not exist and no flag logic is generated.

Decomposition:
- Package serial_sub_pkg holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2. Encoding 2'd3 is illegal and decodes to IDLE.
  - Default WIDTH constant.
- One sub-module, full_sub_cell (purely combinational):
  - d = a ^ b ^ bin
  - bout = (~a & b) | (~(a ^ b) & bin)
- The controller instantiates exactly one full_sub_cell.

Test Plan:
- WIDTH=4; reset, then start with a=5, b=3 -> done in cycle 5 after start; s=0010, borrow=0; busy high for 4 cycles.
- a=3, b=5 -> s=1110, borrow=1; a=0, b=1 -> s=1111, borrow=1; a=15, b=15 -> s=0000, borrow=0.
- Start a=9, b=4; pulse start with a=1, b=1 while busy -> result s=0101, borrow=0; second request ignored.
- Start a=12, b=7; assert reset on the 2nd RUN cycle -> next cycle all outputs 0, FSM IDLE, no done pulse; then a=12, b=7 -> s=0101.
- Exhaustive sweep: all 256 (a,b) pairs, each issued on the first IDLE cycle -> s == (a-b)&4'hF and borrow == (a<b), with exactly one done pulse per request.
- With SERIAL_SUB_FLAGS_EN: a=6, b=6 -> zero=1, lt=0; a=2, b=7 -> zero=0, lt=1.
